// File: rtl/tile_plane_fetch.sv
// Background tile fetch sequencer: per 8-pixel group reads a tile code and three char-ROM planes,
// double-buffers them and parallel-loads the 3-plane shifter. Flip-screen support: `define TILE_FLIP_EN.
module tile_plane_fetch #(
    parameter int ROM_LAT   = 1,
    parameter int COLS_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 ce_pix,
    input  logic                 hblank,
    input  logic                 vblank,
    input  logic [7:0]           hpos,
    input  logic [7:0]           vpos,
    input  logic                 flip,
    output logic [COLS_LOG2+4:0] vram_addr,
    input  logic [7:0]           vram_data,
    output logic [12:0]          crom_addr,
    input  logic [7:0]           crom_data,
    output logic [7:0]           pinA,
    output logic [7:0]           pinB,
    output logic [7:0]           pinC,
    output logic                 load_n,
    output logic                 clr_n,
    output logic                 underrun
);

    localparam logic [1:0] LAST_CNT = 2'(ROM_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TILE,
        ST_P0,
        ST_P1,
        ST_P2,
        ST_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             cnt_reg, cnt_next;
    logic [7:0]             tile_reg, tile_next;
    logic [2:0][7:0]        stage_reg, stage_next;
    logic [2:0][7:0]        pins_reg, pins_next;
    logic [COLS_LOG2+4:0]   vram_addr_reg, vram_addr_next;
    logic [12:0]            crom_addr_reg, crom_addr_next;
    logic                   load_n_reg, load_n_next;
    logic                   clr_n_reg, clr_n_next;
    logic                   underrun_reg, underrun_next;

    logic                   blank;
    logic                   start_evt;
    logic                   load_evt;
    logic                   cnt_last;
    logic                   busy;
    logic [4:0]             col_inc;
    logic [COLS_LOG2-1:0]   col_sel;
    logic [4:0]             vrow_sel;
    logic [2:0]             row_sel;
    logic [7:0]             plane_byte;

    assign blank     = hblank | vblank;
    assign start_evt = ce_pix && (hpos[2:0] == 3'd0) && !blank;
    assign load_evt  = ce_pix && (hpos[2:0] == 3'd7) && !blank;
    assign cnt_last  = (cnt_reg == LAST_CNT);
    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    // The fetch at the start of group N targets group N+1, hence the +1.
    assign col_inc   = hpos[7:3] + 5'd1;

`ifdef TILE_FLIP_EN
    logic       flip_reg;
    logic [7:0] plane_rev;

    // Flip is latched at the start so one group never mixes orientations.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            flip_reg <= 1'b0;
        end else if (start_evt) begin
            flip_reg <= flip;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign plane_rev[gi] = crom_data[7-gi];
    end

    assign col_sel    = flip ? ~col_inc[COLS_LOG2-1:0] : col_inc[COLS_LOG2-1:0];
    assign vrow_sel   = flip ? ~vpos[7:3] : vpos[7:3];
    assign row_sel    = flip_reg ? ~vpos[2:0] : vpos[2:0];
    assign plane_byte = flip_reg ? plane_rev : crom_data;
`else
    logic unused_flip;

    assign unused_flip = flip;
    assign col_sel     = col_inc[COLS_LOG2-1:0];
    assign vrow_sel    = vpos[7:3];
    assign row_sel     = vpos[2:0];
    assign plane_byte  = crom_data;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        tile_next      = tile_reg;
        stage_next     = stage_reg;
        pins_next      = pins_reg;
        vram_addr_next = vram_addr_reg;
        crom_addr_next = crom_addr_reg;
        load_n_next    = 1'b1;
        underrun_next  = 1'b0;
        clr_n_next     = ~blank;

        // Every fetch state lasts ROM_LAT+1 clocks; data is captured on the last one.
        if (busy) begin
            cnt_next = cnt_last ? 2'd0 : cnt_reg + 2'd1;
        end

        case (state_reg)
            ST_TILE: begin
                if (cnt_last) begin
                    tile_next      = vram_data;
                    crom_addr_next = {2'd0, vram_data, row_sel};
                    state_next     = ST_P0;
                end
            end
            ST_P0: begin
                if (cnt_last) begin
                    stage_next[0]  = plane_byte;
                    crom_addr_next = {2'd1, tile_reg, row_sel};
                    state_next     = ST_P1;
                end
            end
            ST_P1: begin
                if (cnt_last) begin
                    stage_next[1]  = plane_byte;
                    crom_addr_next = {2'd2, tile_reg, row_sel};
                    state_next     = ST_P2;
                end
            end
            ST_P2: begin
                if (cnt_last) begin
                    stage_next[2] = plane_byte;
                    state_next    = ST_DONE;
                end
            end
            default: ;
        endcase

        if (blank) begin
            state_next = ST_IDLE;
        end else if (start_evt) begin
            underrun_next  = busy;
            state_next     = ST_TILE;
            cnt_next       = 2'd0;
            vram_addr_next = {vrow_sel, col_sel};
        end else if (load_evt) begin
            load_n_next = 1'b0;
            state_next  = ST_IDLE;
            if (state_reg == ST_DONE) begin
                pins_next = stage_reg;
            end else begin
                pins_next     = '0;
                underrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 2'd0;
            tile_reg      <= 8'h00;
            stage_reg     <= '0;
            pins_reg      <= '0;
            vram_addr_reg <= '0;
            crom_addr_reg <= '0;
            load_n_reg    <= 1'b1;
            clr_n_reg     <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            tile_reg      <= tile_next;
            stage_reg     <= stage_next;
            pins_reg      <= pins_next;
            vram_addr_reg <= vram_addr_next;
            crom_addr_reg <= crom_addr_next;
            load_n_reg    <= load_n_next;
            clr_n_reg     <= clr_n_next;
            underrun_reg  <= underrun_next;
        end
    end

    assign vram_addr = vram_addr_reg;
    assign crom_addr = crom_addr_reg;
    assign pinA      = pins_reg[0];
    assign pinB      = pins_reg[1];
    assign pinC      = pins_reg[2];
    assign load_n    = load_n_reg;
    assign clr_n     = clr_n_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_tile_plane_fetch.sv
// Bench for tile_plane_fetch: two instances (ROM_LAT=1 and 3) share video timing; a group-level
// reference model predicts load strobes, pins, underrun, clear and VRAM address every clock.
module tb_tile_plane_fetch;

`ifdef TILE_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            nRST, ce_pix, hblank, vblank, flip;
    logic [7:0]      hpos, vpos;
    logic [1:0][9:0] va;
    logic [1:0][7:0] vd;
    logic [1:0][12:0] ca;
    logic [1:0][7:0] cd;
    logic [1:0][7:0] pa, pb, pc;
    logic [1:0]      ln, cl, ur;

    tile_plane_fetch #(.ROM_LAT(1), .COLS_LOG2(5)) dut1 (
        .clk(clk), .nRST(nRST), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .hpos(hpos), .vpos(vpos), .flip(flip),
        .vram_addr(va[0]), .vram_data(vd[0]), .crom_addr(ca[0]), .crom_data(cd[0]),
        .pinA(pa[0]), .pinB(pb[0]), .pinC(pc[0]),
        .load_n(ln[0]), .clr_n(cl[0]), .underrun(ur[0])
    );

    tile_plane_fetch #(.ROM_LAT(3), .COLS_LOG2(5)) dut3 (
        .clk(clk), .nRST(nRST), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .hpos(hpos), .vpos(vpos), .flip(flip),
        .vram_addr(va[1]), .vram_data(vd[1]), .crom_addr(ca[1]), .crom_data(cd[1]),
        .pinA(pa[1]), .pinB(pb[1]), .pinC(pc[1]),
        .load_n(ln[1]), .clr_n(cl[1]), .underrun(ur[1])
    );

    // Memories with registered read and 1 or 3 cycles of latency.
    logic [7:0] vram_mem [1024];
    logic [7:0] crom_mem [8192];
    logic [7:0] vp1, cp1;
    logic [7:0] vp3 [3];
    logic [7:0] cp3 [3];

    always @(posedge clk) begin
        vp1    <= vram_mem[va[0]];
        cp1    <= crom_mem[ca[0]];
        vp3[0] <= vram_mem[va[1]];
        vp3[1] <= vp3[0];
        vp3[2] <= vp3[1];
        cp3[0] <= crom_mem[ca[1]];
        cp3[1] <= cp3[0];
        cp3[2] <= cp3[1];
    end

    assign vd = {vp3[2], vp1};
    assign cd = {cp3[2], cp1};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lowcnt = 0;
    string nm [2] = '{"L1", "L3"};

    // Reference model state, per instance.
    bit         act [2];
    int         st_cyc [2];
    logic [9:0] m_vaddr [2];
    logic       m_fl [2];
    logic [7:0] m_pin [2][3];
    logic       m_ln [2];
    logic       m_ur [2];
    logic       m_clr;

    typedef struct {
        logic [7:0]  vp;
        logic [7:0]  h0;
        int          per;
        logic [7:0]  code;
        logic [7:0]  da, db, dc;
        logic [9:0]  eva;
        logic [12:0] e0, e1, e2;
        logic [23:0] ep1;
        logic        eu1;
        logic [23:0] ep3;
        logic        eu3;
    } vec_t;

    vec_t tbl [$];
    vec_t cv;
    bit   chk_tbl = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[7-b];
        return r;
    endfunction

    function automatic int fetch_clks(input int i);
        return 4 * (((i == 0) ? 1 : 3) + 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]     = 1'b0;
            st_cyc[i]  = 0;
            m_vaddr[i] = '0;
            m_fl[i]    = 1'b0;
            m_ln[i]    = 1'b1;
            m_ur[i]    = 1'b0;
            for (int p = 0; p < 3; p++) m_pin[i][p] = 8'h00;
        end
        m_clr = 1'b0;
    endtask

    // Group-level rules: a fetch is complete once more than 4*(LAT+1) clocks separate start and load.
    task automatic model_edge();
        logic blank, st, ld, fl;
        int k, c, vr, row;
        logic [7:0] tile, b;
        blank = hblank | vblank;
        st = ce_pix && (hpos[2:0] == 3'd0) && !blank;
        ld = ce_pix && (hpos[2:0] == 3'd7) && !blank;
        m_clr = !blank;
        for (int i = 0; i < 2; i++) begin
            k = cyc - st_cyc[i];
            m_ln[i] = 1'b1;
            m_ur[i] = 1'b0;
            if (blank) begin
                act[i] = 1'b0;
            end else if (st) begin
                if (act[i] && k <= fetch_clks(i)) m_ur[i] = 1'b1;
                fl = FLIP_EN && flip;
                c  = ((int'(hpos) >> 3) + 1) % 32;
                vr = int'(vpos) >> 3;
                if (fl) begin
                    c  = 31 - c;
                    vr = 31 - vr;
                end
                m_vaddr[i] = 10'(vr * 32 + c);
                m_fl[i]    = fl;
                act[i]     = 1'b1;
                st_cyc[i]  = cyc;
            end else if (ld) begin
                m_ln[i] = 1'b0;
                if (act[i] && k > fetch_clks(i)) begin
                    tile = vram_mem[m_vaddr[i]];
                    row  = int'(vpos[2:0]);
                    if (m_fl[i]) row = 7 - row;
                    for (int p = 0; p < 3; p++) begin
                        b = crom_mem[p * 2048 + int'(tile) * 8 + row];
                        m_pin[i][p] = m_fl[i] ? rev8(b) : b;
                    end
                end else begin
                    for (int p = 0; p < 3; p++) m_pin[i][p] = 8'h00;
                    m_ur[i] = 1'b1;
                end
                act[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk({"load_n_", nm[i]}, 32'(ln[i]), 32'(m_ln[i]));
            chk({"underrun_", nm[i]}, 32'(ur[i]), 32'(m_ur[i]));
            chk({"clr_n_", nm[i]}, 32'(cl[i]), 32'(m_clr));
            chk({"pinA_", nm[i]}, 32'(pa[i]), 32'(m_pin[i][0]));
            chk({"pinB_", nm[i]}, 32'(pb[i]), 32'(m_pin[i][1]));
            chk({"pinC_", nm[i]}, 32'(pc[i]), 32'(m_pin[i][2]));
            chk({"vram_addr_", nm[i]}, 32'(va[i]), 32'(m_vaddr[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (nRST) model_edge();
        #1;
        compare_all();
        if (ln[0] == 1'b0) lowcnt++;
    endtask

    task automatic table_checks(input int j);
        if (j == 0) begin
            chk("tbl_vram_addr_L1", 32'(va[0]), 32'(cv.eva));
            chk("tbl_vram_addr_L3", 32'(va[1]), 32'(cv.eva));
        end
        if (j == 2) chk("tbl_crom_p0", 32'(ca[0]), 32'(cv.e0));
        if (j == 4) chk("tbl_crom_p1", 32'(ca[0]), 32'(cv.e1));
        if (j == 6) chk("tbl_crom_p2", 32'(ca[0]), 32'(cv.e2));
        if (j == 7 * cv.per) begin
            chk("tbl_pins_L1", 32'({pa[0], pb[0], pc[0]}), 32'(cv.ep1));
            chk("tbl_underrun_L1", 32'(ur[0]), 32'(cv.eu1));
            chk("tbl_pins_L3", 32'({pa[1], pb[1], pc[1]}), 32'(cv.ep3));
            chk("tbl_underrun_L3", 32'(ur[1]), 32'(cv.eu3));
            chk("tbl_load_n", 32'(ln), 32'(2'b00));
        end
    endtask

    // One 8-pixel group, ce_pix on the first clock of each pixel; vblank high for clocks [vb_from, vb_to).
    task automatic run_group(input logic [7:0] h0, input int per, input logic hb,
                             input int vb_from, input int vb_to);
        int j;
        j = 0;
        for (int px = 0; px < 8; px++) begin
            for (int c = 0; c < per; c++) begin
                hpos   = 8'(h0 + 8'(px));
                ce_pix = (c == 0);
                hblank = hb;
                vblank = (j >= vb_from) && (j < vb_to);
                cycle();
                if (chk_tbl) table_checks(j);
                j++;
            end
        end
    endtask

    task automatic pix(input logic [7:0] h, input int per);
        for (int c = 0; c < per; c++) begin
            hpos   = h;
            ce_pix = (c == 0);
            hblank = 1'b0;
            vblank = 1'b0;
            cycle();
        end
    endtask

    task automatic add_vec(input logic [7:0] vp, input logic [7:0] h0, input int per,
                           input logic [7:0] code, input logic [7:0] da, input logic [7:0] db,
                           input logic [7:0] dc, input logic [9:0] eva, input logic [12:0] e0,
                           input logic [12:0] e1, input logic [12:0] e2, input logic [23:0] ep1,
                           input logic eu1, input logic [23:0] ep3, input logic eu3);
        vec_t v;
        v.vp = vp; v.h0 = h0; v.per = per; v.code = code;
        v.da = da; v.db = db; v.dc = dc; v.eva = eva;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.ep1 = ep1; v.eu1 = eu1; v.ep3 = ep3; v.eu3 = eu3;
        tbl.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int vbg, vbf;
        bit vbl;
        logic [7:0] base;

        for (int a = 0; a < 1024; a++) vram_mem[a] = 8'($urandom);
        for (int a = 0; a < 8192; a++) crom_mem[a] = 8'($urandom);

        add_vec(8'h13, 8'h00, 2, 8'h5A, 8'hA1, 8'hB2, 8'hC3, 10'h041,
                13'h02D3, 13'h0AD3, 13'h12D3, 24'hA1B2C3, 1'b0, 24'h000000, 1'b1);
        add_vec(8'h13, 8'hF8, 3, 8'h3C, 8'h11, 8'h22, 8'h33, 10'h040,
                13'h01E3, 13'h09E3, 13'h11E3, 24'h112233, 1'b0, 24'h112233, 1'b0);
        add_vec(8'hFF, 8'h78, 1, 8'hC7, 8'h44, 8'h55, 8'h66, 10'h3F0,
                13'h063F, 13'h0E3F, 13'h163F, 24'h000000, 1'b1, 24'h000000, 1'b1);
        add_vec(8'h40, 8'h08, 2, 8'h00, 8'h80, 8'h01, 8'hFF, 10'h102,
                13'h0000, 13'h0800, 13'h1000, 24'h8001FF, 1'b0, 24'h000000, 1'b1);

        nRST = 1'b0; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0; flip = 1'b0;
        hpos = 8'h00; vpos = 8'h00;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            chk({"rst_load_n_", nm[i]}, 32'(ln[i]), 32'd1);
            chk({"rst_clr_n_", nm[i]}, 32'(cl[i]), 32'd0);
            chk({"rst_underrun_", nm[i]}, 32'(ur[i]), 32'd0);
            chk({"rst_pins_", nm[i]}, 32'({pa[i], pb[i], pc[i]}), 32'd0);
            chk({"rst_vram_addr_", nm[i]}, 32'(va[i]), 32'd0);
            chk({"rst_crom_addr_", nm[i]}, 32'(ca[i]), 32'd0);
        end
        #2 nRST = 1'b1;

        // Directed groups from the table.
        foreach (tbl[t]) begin
            cv = tbl[t];
            vpos = cv.vp;
            flip = 1'b0;
            vram_mem[cv.eva] = cv.code;
            crom_mem[cv.e0]  = cv.da;
            crom_mem[cv.e1]  = cv.db;
            crom_mem[cv.e2]  = cv.dc;
            chk_tbl = 1'b1;
            run_group(cv.h0, cv.per, 1'b0, 1000, 1000);
            chk_tbl = 1'b0;
        end

        // Abort: a new start while the previous fetch is still running.
        vpos = 8'h21;
        pix(8'h00, 1); pix(8'h01, 1); pix(8'h02, 1);
        pix(8'h08, 1);
        chk("abort_underrun_L1", 32'(ur[0]), 32'd1);
        chk("abort_underrun_L3", 32'(ur[1]), 32'd1);
        chk("abort_col", 32'(va[0][4:0]), 32'd2);
        for (int h = 9; h < 16; h++) pix(8'(h), 2);

        // vblank rising mid-fetch: no load strobe, clear held low.
        lowcnt = 0;
        run_group(8'h10, 2, 1'b0, 5, 1000);
        chk("vblank_no_load", 32'(lowcnt), 32'd0);
        chk("vblank_clr_n", 32'(cl[0]), 32'd0);
        run_group(8'h18, 2, 1'b0, 0, 4);
        chk("vblank_end_loads", 32'(lowcnt), 32'd1);
        chk("vblank_end_clr_n", 32'(cl[0]), 32'd1);

        // Asynchronous reset while the ROM_LAT=1 instance sits in the second plane fetch.
        run_group(8'h00, 2, 1'b0, 1000, 1000);
        for (int h = 8'h20; h < 8'h25; h++) pix(8'(h), 1);
        #2 nRST = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk({"arst_load_n_", nm[i]}, 32'(ln[i]), 32'd1);
            chk({"arst_clr_n_", nm[i]}, 32'(cl[i]), 32'd0);
            chk({"arst_pins_", nm[i]}, 32'({pa[i], pb[i], pc[i]}), 32'd0);
            chk({"arst_crom_addr_", nm[i]}, 32'(ca[i]), 32'd0);
        end
        model_reset();
        #2 nRST = 1'b1;
        pix(8'h25, 1); pix(8'h26, 1); pix(8'h27, 1);

        // Randomized scan lines against the reference model.
        for (int line = 0; line < 10; line++) begin
            vpos = 8'($urandom);
            flip = 1'($urandom);
            base = 8'($urandom_range(0, 31) * 8);
            vbl  = ($urandom_range(0, 3) == 0);
            vbg  = $urandom_range(0, 5);
            for (int g = 0; g < 6; g++) begin
                int per;
                per = $urandom_range(1, 3);
                vbf = 1000;
                if (vbl && g == vbg) vbf = $urandom_range(0, 7 * per);
                if (vbl && g > vbg) vbf = 0;
                run_group(8'(base + 8'(8 * g)), per, 1'b0, vbf, 1000);
            end
            run_group(8'(base + 8'd48), 1, 1'b1, 1000, 1000);
            run_group(8'(base + 8'd56), 1, 1'b1, 1000, 1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
